// File: rtl/maxnet_loader.sv
// Streams five IEEE-754 operands into the Maxnet model, pulses start, then
// captures the winner (or a quiet-NaN timeout marker) for a downstream consumer.
module maxnet_loader #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [31:0] eps,
   output logic [31:0] a1,
   output logic [31:0] a2,
   output logic [31:0] a3,
   output logic [31:0] a4,
   output logic        start,
   input  logic        finish,
   input  logic [31:0] mx_out,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_timeout,
   output logic        busy
);

   // The counter only has to reach TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {LOAD, START, WAIT, RESULT} state_t;

   state_t           state, state_nx;
   logic [2:0]       idx;
   logic [CNT_W-1:0] cnt;
   logic             take;
   logic             timed_out;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      start     = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      take      = 1'b0;
      timed_out = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            take     = in_valid;
            if (in_valid && idx == 3'd4) state_nx = START;
         end
         START: begin
            start    = 1'b1;
            state_nx = WAIT;
         end
         WAIT: begin
            // finish has priority over an expiring counter
            if (finish) begin
               state_nx = RESULT;
            end else if (cnt == CNT_LAST) begin
               timed_out = 1'b1;
               state_nx  = RESULT;
            end
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         idx   <= 3'd0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (take) idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
         else if (state == RESULT && res_ready) idx <= 3'd0;
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eps <= '0;
         a1  <= '0;
         a2  <= '0;
         a3  <= '0;
         a4  <= '0;
      end else if (take) begin
         case (idx)
            3'd0:    eps <= in_data;
            3'd1:    a1  <= in_data;
            3'd2:    a2  <= in_data;
            3'd3:    a3  <= in_data;
            default: a4  <= in_data;
         endcase
      end
   end

   // Result stays put through RESULT and LOAD until the next run captures.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data    <= '0;
         res_timeout <= 1'b0;
      end else if (state == WAIT && finish) begin
         res_data    <= mx_out;
         res_timeout <= 1'b0;
      end else if (timed_out) begin
         res_data    <= QNAN;
         res_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_maxnet_loader.sv
// Scoreboard bench for maxnet_loader: directed operand streams, a stub Maxnet
// model that pulses finish after a programmable number of WAIT cycles.
module tb_maxnet_loader;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [31:0] eps, a1, a2, a3, a4;
   logic        start;
   logic        finish = 1'b0;
   logic [31:0] mx_out = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_timeout;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int fin_delay = 0;
   int fin_cnt = -1;
   int starts = 0;
   logic [32:0] exp_q[$];
   logic [31:0] vec[5];

   maxnet_loader #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .eps(eps), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .start(start), .finish(finish),
      .mx_out(mx_out), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_timeout(res_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Stub model: finish pulses during the fin_delay-th WAIT cycle; 0 = never.
   always @(negedge clk) begin
      if (rst) begin
         fin_cnt = -1;
         finish  = 1'b0;
      end else begin
         finish = 1'b0;
         if (start) begin
            starts++;
            fin_cnt = (fin_delay > 0) ? fin_delay : -1;
         end else if (fin_cnt > 0) begin
            fin_cnt--;
            if (fin_cnt == 0) begin
               finish  = 1'b1;
               fin_cnt = -1;
            end
         end
      end
   end

   // Monitor: compares every delivered result against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         chk("ready_valid_exclusive", {32'd0, in_ready & res_valid}, 33'd0);
         if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", {res_timeout, res_data}, 33'h1_FFFF_FFFF);
            end else begin
               chk("result", {res_timeout, res_data}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] w, input bit gap);
      int k;
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = w;
      k = 0;
      while (!in_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      if (k == 50) chk("in_ready_timeout", 33'd0, 33'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic run(input bit gap, input int d, input logic [31:0] mx,
                      input logic [32:0] exp_res, input int exp_lat, input int stall,
                      input string tag);
      int n;
      logic [31:0] held;
      fin_delay = d;
      mx_out    = mx;
      starts    = 0;
      res_ready = (stall == 0);
      for (int i = 0; i < 5; i++) begin
         push_word(vec[i], gap && i > 0);
         if (i < 4) chk({tag, "_no_early_start"}, {32'd0, start}, 33'd0);
      end
      exp_q.push_back(exp_res);
      chk({tag, "_start_after_last"}, {32'd0, start}, 33'd1);
      chk({tag, "_in_ready_low"}, {32'd0, in_ready}, 33'd0);
      chk({tag, "_eps"}, {1'b0, eps}, {1'b0, vec[0]});
      chk({tag, "_a1"}, {1'b0, a1}, {1'b0, vec[1]});
      chk({tag, "_a2"}, {1'b0, a2}, {1'b0, vec[2]});
      chk({tag, "_a3"}, {1'b0, a3}, {1'b0, vec[3]});
      chk({tag, "_a4"}, {1'b0, a4}, {1'b0, vec[4]});
      n = 0;
      while (!res_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_latency"}, 33'(n), 33'(exp_lat));
      if (stall > 0) begin
         held = res_data;
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, {32'd0, res_valid}, 33'd1);
            chk({tag, "_stall_data"}, {1'b0, res_data}, {1'b0, held});
            chk({tag, "_stall_in_ready"}, {32'd0, in_ready}, 33'd0);
         end
         res_ready = 1'b1;
      end
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_result_delivered"}, 33'(exp_q.size()), 33'd0);
      chk({tag, "_back_to_load"}, {31'd0, in_ready, busy}, 33'b10);
      chk({tag, "_res_valid_low"}, {32'd0, res_valid}, 33'd0);
      chk({tag, "_one_start"}, 33'(starts), 33'd1);
      chk({tag, "_eps_held"}, {1'b0, eps}, {1'b0, vec[0]});
      chk({tag, "_a4_held"}, {1'b0, a4}, {1'b0, vec[4]});
      chk({tag, "_timeout_held"}, {32'd0, res_timeout}, {32'd0, exp_res[32]});
   endtask

   initial begin
      #12;
      chk("reset_ctrl", {29'd0, in_ready, busy, start, res_valid}, 33'b1000);
      chk("reset_result", {res_timeout, res_data}, 33'd0);
      chk("reset_ops", {1'b0, eps | a1 | a2 | a3 | a4}, 33'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      vec[0] = 32'hBE4CCCCD; vec[1] = 32'h461C3FA7; vec[2] = 32'hC61C3FA7;
      vec[3] = 32'h00000000; vec[4] = 32'h3FA66666;
      run(1'b0, 10, 32'h461C3FA7, {1'b0, 32'h461C3FA7}, 11, 0, "nominal");
      run(1'b1, 10, 32'h461C3FA7, {1'b0, 32'h461C3FA7}, 11, 0, "gapped");
      run(1'b0, 5, 32'h3FA66666, {1'b0, 32'h3FA66666}, 6, 15, "stall");
      run(1'b0, 0, 32'h12345678, {1'b1, 32'h7FC00000}, TO + 1, 0, "timeout");
      run(1'b0, TO, 32'hC61C3FA7, {1'b0, 32'hC61C3FA7}, TO + 1, 0, "last_cycle_finish");

      // Reset after three words: partial load must be discarded.
      vec[0] = 32'h11111111; vec[1] = 32'h22222222; vec[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) push_word(vec[i], 1'b0);
      rst = 1'b1;
      #2;
      chk("midrst_ctrl", {29'd0, in_ready, busy, start, res_valid}, 33'b1000);
      chk("midrst_ops", {1'b0, eps | a1 | a2}, 33'd0);
      chk("midrst_result", {res_timeout, res_data}, 33'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      vec[0] = 32'h3F800000; vec[1] = 32'h40000000; vec[2] = 32'h40400000;
      vec[3] = 32'h40800000; vec[4] = 32'h40A00000;
      run(1'b0, 3, 32'h40A00000, {1'b0, 32'h40A00000}, 4, 0, "post_reset");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
